// File: rtl/mbus_tx_sequencer.sv
// rtl/mbus_tx_sequencer.sv - buffers one message and walks the MBus wrapper TX handshake word by word
module mbus_tx_sequencer #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      LOAD_VALID,
    input  logic [31:0]               LOAD_DATA,
    output logic                      LOAD_READY,
    input  logic                      CMD_VALID,
    input  logic [31:0]               CMD_ADDR,
    input  logic                      CMD_PRIORITY,
    output logic                      CMD_READY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [1:0]                DONE_STATUS,
    output logic [$clog2(DEPTH):0]    DONE_WORDS,
    output logic [31:0]               TX_ADDR,
    output logic [31:0]               TX_DATA,
    output logic                      TX_PEND,
    output logic                      TX_REQ,
    output logic                      TX_PRIORITY,
    input  logic                      TX_ACK,
    input  logic                      TX_SUCC,
    input  logic                      TX_FAIL,
    output logic                      TX_RESP_ACK
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [TIMEOUT_W-1:0] TLIMIT = {TIMEOUT_W{1'b1}} - 1'b1;
    localparam logic [1:0] ST_SUCC = 2'b00, ST_FAIL = 2'b01, ST_EMPTY = 2'b10, ST_TMO = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACKLOW, S_RESULT, S_RESP, S_DONE} state_t;

    state_t                state;
    logic [31:0]           mem [DEPTH];
    logic [AW:0]           count, words_done, remaining;
    logic [AW-1:0]         wptr, rptr;
    logic [TIMEOUT_W-1:0]  tcnt;
    logic [1:0]            status;
    logic                  wr, waiting, timeout;

    assign LOAD_READY = (state == S_IDLE) && (count < FULL);
    assign CMD_READY  = (state == S_IDLE);
    assign BUSY       = (state != S_IDLE);
    // A command in the same cycle takes precedence over a load.
    assign wr         = LOAD_VALID && LOAD_READY && !CMD_VALID;
    assign remaining  = count - words_done;
    assign waiting    = (state == S_REQ) || (state == S_ACKLOW) || (state == S_RESULT) || (state == S_RESP);
    // Leaving on the edge after tcnt hits all-ones-minus-one gives 2^W-1 cycles in the state.
    assign timeout    = waiting && (tcnt == TLIMIT);

    always_ff @(posedge CLK) begin
        if (wr) mem[wptr] <= LOAD_DATA;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= S_IDLE;
            count       <= '0;
            words_done  <= '0;
            wptr        <= '0;
            rptr        <= '0;
            tcnt        <= '0;
            status      <= ST_SUCC;
            DONE        <= 1'b0;
            DONE_STATUS <= 2'b00;
            DONE_WORDS  <= '0;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_PEND     <= 1'b0;
            TX_REQ      <= 1'b0;
            TX_PRIORITY <= 1'b0;
            TX_RESP_ACK <= 1'b0;
        end else begin
            DONE <= 1'b0;
            tcnt <= waiting ? tcnt + 1'b1 : '0;
            if (timeout) begin
                TX_REQ      <= 1'b0;
                TX_PEND     <= 1'b0;
                TX_RESP_ACK <= 1'b0;
                DONE        <= 1'b1;
                DONE_STATUS <= ST_TMO;
                DONE_WORDS  <= words_done;
                tcnt        <= '0;
                state       <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (CMD_VALID) begin
                            TX_ADDR     <= CMD_ADDR;
                            TX_PRIORITY <= CMD_PRIORITY;
                            words_done  <= '0;
                            if (count == '0) begin
                                DONE        <= 1'b1;
                                DONE_STATUS <= ST_EMPTY;
                                DONE_WORDS  <= '0;
                            end else begin
                                TX_REQ  <= 1'b1;
                                TX_DATA <= mem[rptr];
                                TX_PEND <= (count > ONE);
                                tcnt    <= '0;
                                state   <= S_REQ;
                            end
                        end else if (wr) begin
                            count <= count + 1'b1;
                            wptr  <= wptr + 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (TX_FAIL) begin
                            status      <= ST_FAIL;
                            TX_REQ      <= 1'b0;
                            TX_PEND     <= 1'b0;
                            TX_RESP_ACK <= 1'b1;
                            tcnt        <= '0;
                            state       <= S_RESP;
                        end else if (TX_ACK) begin
                            TX_REQ     <= 1'b0;
                            rptr       <= rptr + 1'b1;
                            words_done <= words_done + 1'b1;
                            tcnt       <= '0;
                            if (remaining == ONE) begin
                                TX_PEND <= 1'b0;
                                state   <= S_RESULT;
                            end else begin
                                state <= S_ACKLOW;
                            end
                        end
                    end
                    S_ACKLOW: begin
                        if (TX_FAIL) begin
                            status      <= ST_FAIL;
                            TX_PEND     <= 1'b0;
                            TX_RESP_ACK <= 1'b1;
                            tcnt        <= '0;
                            state       <= S_RESP;
                        end else if (!TX_ACK) begin
                            TX_REQ  <= 1'b1;
                            TX_DATA <= mem[rptr];
                            TX_PEND <= (remaining > ONE);
                            tcnt    <= '0;
                            state   <= S_REQ;
                        end
                    end
                    S_RESULT: begin
                        if (TX_FAIL || TX_SUCC) begin
                            status      <= TX_FAIL ? ST_FAIL : ST_SUCC;
                            TX_RESP_ACK <= 1'b1;
                            tcnt        <= '0;
                            state       <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        if (!TX_SUCC && !TX_FAIL) begin
                            TX_RESP_ACK <= 1'b0;
                            DONE        <= 1'b1;
                            DONE_STATUS <= status;
                            DONE_WORDS  <= words_done;
                            tcnt        <= '0;
                            state       <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        count <= '0;
                        rptr  <= '0;
                        wptr  <= '0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mbus_tx_sequencer.sv
// tb/tb_mbus_tx_sequencer.sv - randomized wrapper-side model and scoreboard for mbus_tx_sequencer
module tb_mbus_tx_sequencer;
    localparam int DEPTH = 8;
    localparam int TW    = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        LOAD_VALID, CMD_VALID, CMD_PRIORITY;
    logic [31:0] LOAD_DATA, CMD_ADDR;
    logic        LOAD_READY, CMD_READY, BUSY, DONE;
    logic [1:0]  DONE_STATUS;
    logic [3:0]  DONE_WORDS;
    logic [31:0] TX_ADDR, TX_DATA;
    logic        TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK;
    logic        TX_ACK, TX_SUCC, TX_FAIL;

    int checks = 0;
    int errors = 0;
    logic [31:0] msg[$];

    always #5 CLK = ~CLK;

    mbus_tx_sequencer #(.DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .LOAD_READY(LOAD_READY),
        .CMD_VALID(CMD_VALID), .CMD_ADDR(CMD_ADDR), .CMD_PRIORITY(CMD_PRIORITY),
        .CMD_READY(CMD_READY), .BUSY(BUSY), .DONE(DONE),
        .DONE_STATUS(DONE_STATUS), .DONE_WORDS(DONE_WORDS),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
        .TX_PRIORITY(TX_PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC),
        .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK)
    );

    // Offers words at the negedge; the model accepts while it holds fewer than DEPTH.
    task automatic load_words(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            logic        exp_ready;
            d = (i == 0) ? first : $urandom;
            exp_ready = (msg.size() < DEPTH);
            LOAD_VALID = 1'b1;
            LOAD_DATA  = d;
            checks++;
            if (LOAD_READY !== exp_ready) begin
                errors++;
                $display("FAIL load_ready word %0d: got %b want %b", i, LOAD_READY, exp_ready);
            end
            if (exp_ready) msg.push_back(d);
            @(negedge CLK);
        end
        LOAD_VALID = 1'b0;
    endtask

    // outcome: 0 succ, 1 fail, 2 succ+fail, 3 fail before word midj, 4 never ack.
    task automatic run_msg(input int outcome, input int midj, input bit busy_load,
                           input bit same_load, input logic [31:0] addr, input bit prio);
        int          n, idx, delay, cyc, req_cycles, exp_words;
        bit          got_done, responded, req_prev;
        logic [31:0] held_data;
        logic        held_pend;
        logic [1:0]  exp_st;
        n = msg.size(); idx = 0; cyc = 0; req_cycles = 0;
        got_done = 0; responded = 0; req_prev = 0;
        held_data = '0; held_pend = 1'b0;
        if (n == 0)            exp_st = 2'b10;
        else if (outcome == 4) exp_st = 2'b11;
        else if (outcome == 0) exp_st = 2'b00;
        else                   exp_st = 2'b01;
        exp_words = (n == 0 || outcome == 4) ? 0 : (outcome == 3 ? midj : n);

        CMD_VALID = 1'b1; CMD_ADDR = addr; CMD_PRIORITY = prio;
        if (same_load) begin LOAD_VALID = 1'b1; LOAD_DATA = $urandom; end
        @(negedge CLK);
        CMD_VALID = 1'b0; LOAD_VALID = 1'b0;
        delay = $urandom_range(0, 3);
        while (!got_done && cyc < 300) begin
            if (BUSY) begin
                checks++;
                if (TX_ADDR !== addr || TX_PRIORITY !== prio) begin
                    errors++;
                    $display("FAIL addr_prio: got %h/%b want %h/%b", TX_ADDR, TX_PRIORITY, addr, prio);
                end
            end
            if (DONE) begin
                got_done = 1;
                checks++;
                if (DONE_STATUS !== exp_st || DONE_WORDS !== 4'(exp_words)) begin
                    errors++;
                    $display("FAIL done_result: got status %b words %0d want status %b words %0d",
                             DONE_STATUS, DONE_WORDS, exp_st, exp_words);
                end
            end else begin
                if (TX_REQ) begin
                    req_cycles++;
                    if (!req_prev) begin
                        checks++;
                        if (idx >= n || TX_DATA !== msg[idx] || TX_PEND !== (idx < n - 1)) begin
                            errors++;
                            $display("FAIL word %0d: got data %h pend %b want data %h pend %b",
                                     idx, TX_DATA, TX_PEND, (idx < n) ? msg[idx] : 32'h0, (idx < n - 1));
                        end
                        held_data = TX_DATA; held_pend = TX_PEND;
                    end else if (TX_DATA !== held_data || TX_PEND !== held_pend) begin
                        checks++; errors++;
                        $display("FAIL req_stable: got %h/%b want %h/%b", TX_DATA, TX_PEND, held_data, held_pend);
                    end
                    if (!TX_ACK && !TX_FAIL && outcome != 4) begin
                        if (delay > 0) delay--;
                        else if (outcome == 3 && idx == midj) TX_FAIL = 1'b1;
                        else begin TX_ACK = 1'b1; idx++; delay = $urandom_range(0, 3); end
                    end
                end else if (TX_ACK) begin
                    TX_ACK = 1'b0;
                end else if (idx == n && n > 0 && !responded && !TX_RESP_ACK) begin
                    if (delay > 0) delay--;
                    else begin
                        TX_SUCC = (outcome == 0 || outcome == 2);
                        TX_FAIL = (outcome == 1 || outcome == 2);
                        responded = 1; delay = $urandom_range(0, 3);
                    end
                end
                if (TX_RESP_ACK && (TX_SUCC || TX_FAIL)) begin
                    if (delay > 0) delay--;
                    else begin TX_SUCC = 1'b0; TX_FAIL = 1'b0; end
                end
                req_prev = TX_REQ;
            end
            if (busy_load && !got_done) begin
                LOAD_VALID = 1'b1; LOAD_DATA = $urandom;
                if (BUSY) begin
                    checks++;
                    if (LOAD_READY !== 1'b0) begin
                        errors++;
                        $display("FAIL load_ready_busy: got %b want 0", LOAD_READY);
                    end
                end
            end
            @(negedge CLK);
            cyc++;
        end
        LOAD_VALID = 1'b0; TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout: got no DONE in %0d cycles want DONE", cyc);
        end
        if (outcome == 4 || n == 0) begin
            checks++;
            if (req_cycles !== ((n == 0) ? 0 : (1 << TW) - 1)) begin
                errors++;
                $display("FAIL req_cycles: got %0d want %0d", req_cycles, (n == 0) ? 0 : (1 << TW) - 1);
            end
        end
        checks++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || LOAD_READY !== 1'b1 || DONE !== 1'b0 || TX_RESP_ACK !== 1'b0) begin
            errors++;
            $display("FAIL post_done: got cmd_ready %b busy %b load_ready %b done %b resp_ack %b want 1 0 1 0 0",
                     CMD_READY, BUSY, LOAD_READY, DONE, TX_RESP_ACK);
        end
        msg.delete();
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        LOAD_VALID = 1'b0; LOAD_DATA = '0; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_PRIORITY = 1'b0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (LOAD_READY !== 1'b1 || CMD_READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 ||
            DONE_STATUS !== 2'b00 || DONE_WORDS !== 4'd0 || TX_ADDR !== 32'd0 || TX_DATA !== 32'd0 ||
            TX_PEND !== 1'b0 || TX_REQ !== 1'b0 || TX_PRIORITY !== 1'b0 || TX_RESP_ACK !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got lr %b cr %b busy %b done %b req %b resp %b want 1 1 0 0 0 0",
                     LOAD_READY, CMD_READY, BUSY, DONE, TX_REQ, TX_RESP_ACK);
        end
        RESETn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        load_words(1, 32'h0A00feed);
        run_msg(0, 0, 0, 0, 32'hf00000B0, 1'b0);
    endtask

    task automatic test_three_nak();
        msg.delete();
        LOAD_VALID = 1'b1;
        foreach (msg[i]) ;
        load_words(1, 32'hfeedface);
        load_words(1, 32'hF0F0F0F0);
        load_words(1, 32'h0000000F);
        run_msg(1, 0, 0, 0, 32'hf00000C0, 1'b1);
    endtask

    task automatic test_empty();
        run_msg(0, 0, 0, 0, 32'hf00000B0, 1'b0);
    endtask

    task automatic test_timeout();
        load_words(2, 32'h12345678);
        run_msg(4, 0, 0, 0, 32'hf00000D0, 1'b0);
        run_msg(0, 0, 0, 0, 32'hf00000D0, 1'b0);
    endtask

    task automatic test_overflow_busy();
        load_words(DEPTH + 1, 32'hA5A5A5A5);
        run_msg(2, 0, 1, 0, 32'hf00000E0, 1'b1);
    endtask

    task automatic test_same_cycle();
        load_words(2, 32'h5555AAAA);
        run_msg(0, 0, 0, 1, 32'h0000001B, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_words(3, 32'hCAFEF00D);
        CMD_VALID = 1'b1; CMD_ADDR = 32'hf00000F0; CMD_PRIORITY = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        @(negedge CLK);
        #2 RESETn = 1'b0;
        #1;
        checks++;
        if (TX_REQ !== 1'b0 || BUSY !== 1'b0 || TX_ADDR !== 32'd0 || TX_PRIORITY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req %b busy %b addr %h prio %b done %b want 0 0 0 0 0",
                     TX_REQ, BUSY, TX_ADDR, TX_PRIORITY, DONE);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        msg.delete();
        @(negedge CLK);
        run_msg(0, 0, 0, 0, 32'hf00000B0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int n, oc;
            n  = $urandom_range(1, DEPTH);
            oc = $urandom_range(0, 3);
            load_words(n, $urandom);
            run_msg(oc, $urandom_range(0, n - 1), $urandom_range(0, 1), 0, $urandom, $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_nak();
        test_empty();
        test_timeout();
        test_overflow_busy();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
